// File: rtl/data_mem_dp.sv
// rtl/data_mem_dp.sv - dual-read, single-write data memory with hardware clear sweep
//
// Parameters:
//   DATA_W   word width in bits (default 8)
//   ADDR_W   address width; DEPTH = 2**ADDR_W words (default 64)
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              global access enable; no read/write/clear accepted when low
//   clear               single-cycle request to zero the whole array
//   wr_en/wr_addr/wr_data   synchronous write port
//   rd_en/rd_addr1/rd_addr2 read request for both ports
//   rd_data1/rd_data2   registered read data (1-cycle latency)
//   rd_valid            one-cycle strobe when rd_data1/rd_data2 were updated
//   busy                high while the clear sweep runs
//
// Build option:
//   DATA_MEM_BYPASS_EN  defined: write-first collision (read of the address being
//                       written returns wr_data); undefined: read-first.

module data_mem_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] storage [DEPTH];

    // Request qualification. A clear request in READY takes priority and
    // drops any read or write presented in the same cycle.
    logic clr_req;
    logic access_ok;
    logic wr_acc;
    logic rd_acc;

    assign clr_req   = (state == ST_READY) && enable && clear;
    assign access_ok = (state == ST_READY) && enable && !clear;
    assign wr_acc    = access_ok && wr_en;
    assign rd_acc    = access_ok && rd_en;

    // Single array write port shared between the clear sweep and user writes.
    // Gated by rst so a write presented during reset never lands.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end else if (wr_acc) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            storage[mem_waddr] <= mem_wdata;
        end
    end

    // Collision handling: each read port compares against the write address
    // independently. In the read-first build the non-blocking array update
    // naturally returns the pre-write word.
    logic byp1;
    logic byp2;

`ifdef DATA_MEM_BYPASS_EN
    assign byp1 = wr_acc && (rd_addr1 == wr_addr);
    assign byp2 = wr_acc && (rd_addr2 == wr_addr);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    assign rd_next1 = byp1 ? wr_data : storage[rd_addr1];
    assign rd_next2 = byp2 ? wr_data : storage[rd_addr2];

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    rd_valid <= 1'b0;
                    // clr_ptr wraps to 0 naturally after the last address.
                    clr_ptr  <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end

                ST_READY: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_ptr  <= '0;
                        busy     <= 1'b1;
                        rd_valid <= 1'b0;
                    end else if (rd_acc) begin
                        rd_data1 <= rd_next1;
                        rd_data2 <= rd_next2;
                        rd_valid <= 1'b1;
                    end else begin
                        rd_valid <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_CLEAR;
                    clr_ptr  <= '0;
                    busy     <= 1'b1;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dp.sv
// tb/tb_data_mem_dp.sv - scoreboard testbench for data_mem_dp

module tb_data_mem_dp;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_valid;
    logic              busy;

    data_mem_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        string             name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every rd_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_d1"}, int'(rd_data1), int'(e.d1));
                chk({e.name, "_d2"}, int'(rd_data2), int'(e.d2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int a1, input int a2, input int e1, input int e2, input string name);
        exp_t e;
        e.d1 = DATA_W'(e1); e.d2 = DATA_W'(e2); e.name = name;
        exp_q.push_back(e);
        rd_en = 1'b1; rd_addr1 = ADDR_W'(a1); rd_addr2 = ADDR_W'(a2);
        tick();
        rd_en = 1'b0;
    endtask

    // Counts cycles with busy high (bounded), checking rd_data holds.
    task automatic count_busy(input string name, input int hold1, input int hold2);
        int n;
        bit held;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            if (rd_data1 !== DATA_W'(hold1) || rd_data2 !== DATA_W'(hold2)) held = 1'b0;
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, DEPTH);
        chk({name, "_data_hold"}, int'(held), 1);
    endtask

    initial begin
        rst = 1'b1; idle();
        wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;

        // Reset and initial sweep.
        tick();
        tick();
        chk("reset_busy", int'(busy), 1);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data1", int'(rd_data1), 0);
        rst = 1'b0;
        count_busy("init", 0, 0);
        do_read(0, 63, 8'h00, 8'h00, "rd_0_63");

        // Basic write then dual read.
        do_write(5, 8'hA5);
        do_write(6, 8'h3C);
        do_read(5, 6, 8'hA5, 8'h3C, "rd_5_6");
        tick();

        // Collision: write 9 while reading (9,5).
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 8'h77;
`ifdef DATA_MEM_BYPASS_EN
        do_read(9, 5, 8'h77, 8'hA5, "collide_9_5");
`else
        do_read(9, 5, 8'h00, 8'hA5, "collide_9_5");
`endif
        wr_en = 1'b0;
        do_read(9, 9, 8'h77, 8'h77, "rd_9_9");
        tick();

        // enable low: nothing accepted, outputs hold.
        enable = 1'b0; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hFF;
        rd_en = 1'b1; rd_addr1 = 6'd5; rd_addr2 = 6'd6;
        tick();
        tick();
        chk("disabled_rd_valid", int'(rd_valid), 0);
        chk("disabled_hold_d1", int'(rd_data1), 8'h77);
        chk("disabled_hold_d2", int'(rd_data2), 8'h77);
        idle();
        do_read(5, 6, 8'hA5, 8'h3C, "rd_after_disabled");
        tick();

        // Clear pulse with a concurrent write (dropped); rd_en held during sweep.
        clear = 1'b1; wr_en = 1'b1; wr_addr = 6'd2; wr_data = 8'h11;
        tick();
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 6'd5; rd_addr2 = 6'd2;
        chk("clear_busy_next", int'(busy), 1);
        count_busy("clear", 8'hA5, 8'h3C);
        rd_en = 1'b0;
        do_read(5, 2, 8'h00, 8'h00, "rd_after_clear");
        tick();

        // Reset in the middle of a sweep restarts it.
        do_write(3, 8'h42);
        do_read(3, 3, 8'h42, 8'h42, "rd_3");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1;
        tick();
        chk("midsweep_rst_busy", int'(busy), 1);
        chk("midsweep_rst_d1", int'(rd_data1), 0);
        rst = 1'b0;
        count_busy("restart", 0, 0);
        do_read(3, 63, 8'h00, 8'h00, "rd_after_restart");
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_dp.md
Name: data_mem_dp

Overview:
- Parametrised successor to the 8-bit, 64-entry core data memory.
- Provides one synchronous write port and two registered read ports, usable in the same cycle.
- Adds a hardware clear sequencer, replacing the old per-word reset loop with a DEPTH-cycle sweep and a busy flag.
- Sits between the core datapath and operand fetch; a read or write is a single-cycle request with no stall except during clear.

Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 6, address width in bits; DEPTH = 2**ADDR_W words (default 64)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global access enable; when low, no read or write is accepted
- clear  in  1  single-cycle request to zero the whole array
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request, applies to both read ports
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  registered read data, port 1
- rd_data2  out  DATA_W  registered read data, port 2
- rd_valid  out  1  high for one cycle when rd_data1/rd_data2 were updated
- busy  out  1  high while the clear sweep runs

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State machine: CLEAR and READY.
- Reset values: rd_data1=0, rd_data2=0, rd_valid=0, busy=1, clr_ptr=0, state=CLEAR.
- Array contents are not reset directly; the CLEAR sweep zeroes them.
- CLEAR state:
  - Each cycle writes 0 to storage[clr_ptr], then increments clr_ptr.
  - The cycle that writes address DEPTH-1 moves to READY.
  - busy drops the following cycle, so busy is high for exactly DEPTH cycles after rst deasserts.
  - clr_ptr wraps to 0 on that transition.
- While busy=1:
  - wr_en, rd_en and clear are ignored.
  - rd_valid=0.
  - rd_data1/rd_data2 hold their values.
- READY state, clear=1 and enable=1:
  - Moves to CLEAR with clr_ptr=0.
  - Any write or read in that same cycle is dropped.
  - busy=1 from the next cycle.
- READY state, write:
  - enable=1, wr_en=1, clear=0: storage[wr_addr] <= wr_data at the edge.
- READY state, read:
  - enable=1, rd_en=1, clear=0: rd_data1 <= storage[rd_addr1] and rd_data2 <= storage[rd_addr2] at the edge.
  - rd_valid=1 in the next cycle; read latency is 1 cycle.
  - Otherwise rd_valid=0 and the data outputs hold.
- Simultaneous read and write:
  - Both are accepted in one cycle.
  - Collision value is defined under Optional Feature.
  - rd_addr1 == rd_addr2 is legal; both ports return the same word.
- Reset during CLEAR, or at any time: the sweep restarts from clr_ptr=0 and outputs return to their reset values.
- Widths: no arithmetic on data; clr_ptr is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: DATA_MEM_BYPASS_EN
- Defined (write-first): a read port whose address equals wr_addr in a cycle with an accepted write returns wr_data. Each port compares independently.
- Undefined (read-first): a colliding read returns the pre-write contents, and the new value is visible from the next read.
- The write to the array is identical in both builds.

Test Plan:
- rst high 2 cycles, then low -> busy=1 for exactly 64 cycles, then 0; rd_data1=rd_data2=0, rd_valid=0 throughout; a read of addresses 0 and 63 afterwards returns 0x00, 0x00.
- Write 0xA5 to addr 5 and 0x3C to addr 6, then read (5,6) -> next cycle rd_data1=0xA5, rd_data2=0x3C, rd_valid=1 for one cycle.
- Same cycle: write 0x77 to addr 9 and read (9,5) -> with DATA_MEM_BYPASS_EN, rd_data1=0x77; without it, rd_data1=0x00, and the read of addr 9 in the next cycle returns 0x77; rd_data2=0xA5 in both builds.
- enable=0 with wr_en=1 (addr 5, 0xFF) and rd_en=1 -> rd_valid stays 0, outputs hold; a later read of addr 5 returns 0xA5.
- clear pulse in READY while writing 0x11 to addr 2 -> write dropped, busy=1 for 64 cycles; rd_en during the sweep gives no rd_valid; afterwards addr 5 reads 0x00.
- Assert rst at clear cycle 30 -> busy stays 1 and the sweep restarts, completing 64 cycles after rst deasserts.
